// File: rtl/button_pio_poller.sv
// Avalon-MM master that polls a push-button PIO: reads and clears edge-capture, then reads levels.
// Optional macro BUTTON_POLLER_TOGGLE_EN adds a per-button on/off latch driven by press pulses.
module button_pio_poller #(
  parameter int WIDTH        = 3,
  parameter int POLL_DIV     = 50000,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] btn_state,
  output logic             busy,
  output logic [WIDTH-1:0] toggle_out
);

  localparam int CNT_W = 25;
  localparam int LAT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_DIV - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_EDGE = 2'd1,
    S_WR_CLR  = 2'd2,
    S_RD_DATA = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [WIDTH-1:0]   cap_q, cap_d;
  logic [WIDTH-1:0]   btn_q, btn_d;
  logic [WIDTH-1:0]   press_q, press_d;
  logic               busy_q, busy_d;
  logic [1:0]         addr_q, addr_d;
  logic               cs_q, cs_d;
  logic               wn_q, wn_d;
  logic [31:0]        wd_q, wd_d;
  logic [WIDTH-1:0]   rd_bits_s;
  logic               unused_rd_s;

  assign rd_bits_s   = avm_readdata[WIDTH-1:0];
  assign unused_rd_s = ^avm_readdata[31:WIDTH];

  // Sequencer: idle countdown, read/clear/read transaction, capture of edge and level data
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    cap_d   = cap_q;
    btn_d   = btn_q;
    press_d = {WIDTH{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          lat_d   = {LAT_W{1'b0}};
          state_d = S_RD_EDGE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_EDGE: begin
        if (lat_q == LAT_LAST) begin
          cap_d   = rd_bits_s;
          lat_d   = {LAT_W{1'b0}};
          state_d = (rd_bits_s != {WIDTH{1'b0}}) ? S_WR_CLR : S_RD_DATA;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_WR_CLR: begin
        // Pulse appears in the first RD_DATA cycle; WR_CLR is only entered with cap != 0
        press_d = cap_q;
        lat_d   = {LAT_W{1'b0}};
        state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (lat_q == LAT_LAST) begin
          btn_d   = rd_bits_s;
          lat_d   = {LAT_W{1'b0}};
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        lat_d   = {LAT_W{1'b0}};
      end
    endcase
  end

  // Bus drive values for the upcoming state, so outputs come straight from flops
  always_comb begin
    addr_d = ADDR_DATA;
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    wd_d   = 32'd0;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_IDLE: begin
        cs_d = 1'b0;
      end
      S_RD_EDGE: begin
        addr_d = ADDR_EDGE;
        cs_d   = 1'b1;
      end
      S_WR_CLR: begin
        addr_d               = ADDR_EDGE;
        cs_d                 = 1'b1;
        wn_d                 = 1'b0;
        wd_d[WIDTH-1:0]      = cap_d;
      end
      S_RD_DATA: begin
        addr_d = ADDR_DATA;
        cs_d   = 1'b1;
      end
      default: begin
        cs_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset forces the bus idle immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      lat_q   <= {LAT_W{1'b0}};
      cap_q   <= {WIDTH{1'b0}};
      btn_q   <= {WIDTH{1'b1}};
      press_q <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      addr_q  <= ADDR_DATA;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      wd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      cap_q   <= cap_d;
      btn_q   <= btn_d;
      press_q <= press_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      wd_q    <= wd_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = wd_q;
  assign press_pulse    = press_q;
  assign btn_state      = btn_q;
  assign busy           = busy_q;

`ifdef BUTTON_POLLER_TOGGLE_EN
  logic [WIDTH-1:0] toggle_q;

  // Toggle flips together with the press pulse becoming visible
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= {WIDTH{1'b0}};
    end else begin
      toggle_q <= toggle_q ^ press_d;
    end
  end

  assign toggle_out = toggle_q;
`else
  assign toggle_out = {WIDTH{1'b0}};
`endif

endmodule

// File: doc/button_pio_poller.md
Name: button_pio_poller

Overview:
- Avalon-MM master that drives the push-button PIO slave on the guitar-pedal control path.
- On each poll it reads the edge-capture register (address 3) and writes back the captured bits to clear only those bits.
- It then reads the data register (address 0) and presents one-cycle press pulses plus the debounced-by-poll button levels to the effect-select logic.
- Removes the need for Nios software to service the buttons.

Parameters:
- WIDTH, 3, number of button bits handled (slave bits WIDTH-1:0).
- POLL_DIV, 50000, idle cycles between polls; legal range 2..2^24.
- READ_LATENCY, 1, slave read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- avm_address  out  2  slave address
- avm_chipselect  out  1  slave select
- avm_write_n  out  1  active-low write strobe
- avm_writedata  out  32  write data; bits 31:WIDTH always 0
- avm_readdata  in  32  slave read data; only bits WIDTH-1:0 used
- press_pulse  out  WIDTH  one-cycle pulse per captured falling edge (press)
- btn_state  out  WIDTH  last sampled data register, raw active-low level
- busy  out  1  high whenever the FSM is not in IDLE
- toggle_out  out  WIDTH  per-button on/off latch (see Optional Feature)

Behaviour:
- Interface timing:
  - Single clock domain clk; reset_n is asynchronous and active-low.
  - Slave has no waitrequest and a fixed read latency of L = READ_LATENCY.
- Idle bus values: chipselect=0, write_n=1, address=0, writedata=0.
- Reset values:
  - All outputs 0 except avm_write_n=1 and btn_state={WIDTH{1}} (released).
  - FSM=IDLE, poll counter=0, capture register=0.
- FSM states:
  - IDLE:
    - Counter increments each cycle.
    - When it reaches POLL_DIV-1, the counter clears and the FSM goes to RD_EDGE.
    - The counter runs only in IDLE, so the poll period is POLL_DIV plus the transaction length.
  - RD_EDGE:
    - Drive address=3, chipselect=1, write_n=1 from cycle c0 through c0+L, held stable.
    - avm_readdata[WIDTH-1:0] is captured into cap at the end of c0+L.
    - Transaction length is L+1 cycles.
    - Next state: WR_CLR if cap!=0, else RD_DATA.
  - WR_CLR:
    - One cycle: address=3, chipselect=1, write_n=0, writedata={0,cap}.
    - Only bits read as 1 are cleared; edges on other bits latched by the slave are preserved.
    - Next state: RD_DATA.
  - RD_DATA:
    - Same timing as RD_EDGE with address=0.
    - btn_state <= avm_readdata[WIDTH-1:0] at the end of c0+L.
    - Next state: IDLE.
- press_pulse:
  - Equals cap for exactly one cycle: the first RD_DATA cycle, following WR_CLR.
  - 0 at all other times.
  - Never asserted when cap=0.
- Accepted race: an edge on a bit already captured that arrives between the RD_EDGE sample and the WR_CLR cycle is lost. The slave gives clear priority over a new edge. This is acceptable at button rates.
- busy: 1 in every state except IDLE.
- Reset mid-transaction:
  - Immediate return to IDLE; bus lines go to idle values asynchronously.
  - No press_pulse; counter restarts from 0.
- Bits 31:WIDTH of avm_readdata are ignored.

Optional Feature:
- Macro: BUTTON_POLLER_TOGGLE_EN.
- Defined:
  - toggle_out[i] inverts on every cycle press_pulse[i]=1.
  - Reset value 0.
  - Feeds effect bypass on/off.
- Undefined:
  - toggle_out is tied to 0 and no toggle flops are generated.
  - All other behaviour is identical.

Test Plan:
1. Assert reset_n=0 mid-run, hold 3 cycles -> chipselect=0, write_n=1, address=0, press_pulse=0, btn_state=3'b111, busy=0; first chipselect rises POLL_DIV cycles after release.
2. POLL_DIV=8, L=1, slave model edge_capture=3'b010, data=3'b101 -> addr 3 read (2 cycles), one write cycle addr 3 data 0x00000002, addr 0 read, press_pulse=3'b010 for exactly one cycle, btn_state=3'b101, model edge_capture=0.
3. edge_capture=0 at poll -> no write cycle (write_n stays 1 throughout), press_pulse never asserted, busy high for exactly 2(L+1) cycles.
4. edge_capture=3'b101, then new edge on bit 1 injected in the WR_CLR cycle -> writedata=0x5, press_pulse=3'b101, model retains bit 1, next poll pulses 3'b010.
5. READ_LATENCY=3 with a slave model of latency 3 -> address held 4 cycles per read, correct capture, correct pulse value.
6. With BUTTON_POLLER_TOGGLE_EN defined: two polls, each capturing bit 0 -> toggle_out[0] goes 0->1->0; reset asserted during WR_CLR -> toggle_out=0, no pulse, write_n=1 immediately.
